// File: rtl/master_tx.sv
// master_tx: parallel request to serial slave-bus master.
// A request is captured, then address/data/burst are shifted out LSB first
// over 13 SEND cycles. Reads then collect 8 serial bits from the slave before
// a one-cycle completion report in DONE.
// Optional build macro: MASTER_TX_TIMEOUT_EN adds an 8-bit stall timeout that
// ends a stuck transaction in DONE with rsp_err=1 and rsp_rdata=0x00.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | ready for a new request (req_ready=1)
// S_WAIT_SLV  | request held, waiting for slave_ready
// S_SEND      | 13-cycle serial shift of addr/wdata/burst, master_valid=1
// S_READ_WAIT | read: master_ready=1, no read bit captured yet
// S_READ_DATA | read: capturing rx_data bits 1..7 on slave_valid
// S_DONE      | one-cycle completion report (rsp_valid=1)

module master_tx (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [11:0] req_addr,
    input  logic [7:0]  req_wdata,
    input  logic [12:0] req_burst,
    output logic        tx_address,
    output logic        tx_data,
    output logic        tx_burst,
    output logic        master_valid,
    output logic        master_ready,
    output logic        read_en,
    output logic        write_en,
    input  logic        slave_valid,
    input  logic        slave_ready,
    input  logic        rx_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SLV,
        S_SEND,
        S_READ_WAIT,
        S_READ_DATA,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_write;
    logic [11:0] r_addr;
    logic [7:0]  r_wdata;
    logic [12:0] r_burst;
    logic [3:0]  r_bit_cnt;
    logic [2:0]  r_rd_cnt;
    logic [7:0]  r_rdata;

    logic        w_accept;
    logic        w_in_read;
    logic        w_capture;
    logic        w_send_last;
    logic        w_rd_last;
    logic        w_timeout;

    assign w_accept    = (r_state == S_IDLE) && req_valid;
    assign w_in_read   = (r_state == S_READ_WAIT) || (r_state == S_READ_DATA);
    assign w_capture   = w_in_read && slave_valid;
    assign w_send_last = (r_state == S_SEND) && (r_bit_cnt == 4'd12);
    assign w_rd_last   = w_capture && (r_rd_cnt == 3'd7);

`ifdef MASTER_TX_TIMEOUT_EN
    logic [7:0] r_to_cnt;
    logic       r_err;
    logic       w_to_count;

    // Stall cycles: waiting for the slave to become ready, or waiting for a read bit.
    assign w_to_count = ((r_state == S_WAIT_SLV) && !slave_ready) ||
                        (w_in_read && !slave_valid);
    // The 255th consecutive stall cycle ends the transaction.
    assign w_timeout  = w_to_count && (r_to_cnt == 8'd254);

    // Stall counter restarts on every state change and on every captured read bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if ((w_state_nxt != r_state) || w_capture) begin
                r_to_cnt <= '0;
            end else if (w_to_count) begin
                r_to_cnt <= r_to_cnt + 8'd1;
            end
            if (w_accept) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign rsp_err = (r_state == S_DONE) && r_err;
`else
    assign w_timeout = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request capture, shift/capture counters and read data assembly.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_burst   <= '0;
            r_bit_cnt <= '0;
            r_rd_cnt  <= '0;
            r_rdata   <= '0;
        end else begin
            if (w_accept) begin
                r_write  <= req_write;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_burst  <= req_burst;
                r_rd_cnt <= '0;
                r_rdata  <= '0;
            end

            if ((r_state == S_SEND) && !w_send_last) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end else begin
                r_bit_cnt <= '0;
            end

            if (w_capture) begin
                r_rdata[r_rd_cnt] <= rx_data;
                r_rd_cnt          <= r_rd_cnt + 3'd1;
            end

            // A timed-out read reports no data.
            if (w_timeout) begin
                r_rdata <= '0;
            end
        end
    end

    // Next-state decode and state-driven outputs.
    always_comb begin
        w_state_nxt  = r_state;
        req_ready    = 1'b0;
        master_valid = 1'b0;
        master_ready = 1'b0;
        tx_address   = 1'b0;
        tx_data      = 1'b0;
        tx_burst     = 1'b0;
        rsp_valid    = 1'b0;
        read_en      = (r_state != S_IDLE) && !r_write;
        write_en     = (r_state != S_IDLE) && r_write;

        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = S_WAIT_SLV;
                end
            end
            S_WAIT_SLV: begin
                if (slave_ready) begin
                    w_state_nxt = S_SEND;
                end else if (w_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_SEND: begin
                master_valid = 1'b1;
                tx_burst     = r_burst[r_bit_cnt];
                tx_address   = (r_bit_cnt < 4'd12) ? r_addr[r_bit_cnt] : 1'b0;
                tx_data      = (r_write && (r_bit_cnt < 4'd8)) ? r_wdata[r_bit_cnt[2:0]] : 1'b0;
                if (w_send_last) begin
                    w_state_nxt = r_write ? S_DONE : S_READ_WAIT;
                end
            end
            S_READ_WAIT: begin
                master_ready = 1'b1;
                if (w_capture) begin
                    w_state_nxt = S_READ_DATA;
                end else if (w_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_READ_DATA: begin
                master_ready = 1'b1;
                if (w_rd_last || w_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                rsp_valid   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_master_tx.sv
// tb_master_tx: table-driven transactions for master_tx with a response
// scoreboard. Each request pushes its expected completion; a negedge monitor
// pops and compares whenever rsp_valid is seen.
// Define MASTER_TX_TIMEOUT_EN for both files to exercise the timeout build.

module tb_master_tx;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [11:0] req_addr;
    logic [7:0]  req_wdata;
    logic [12:0] req_burst;
    logic        tx_address;
    logic        tx_data;
    logic        tx_burst;
    logic        master_valid;
    logic        master_ready;
    logic        read_en;
    logic        write_en;
    logic        slave_valid;
    logic        slave_ready;
    logic        rx_data;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;

    master_tx dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_burst    (req_burst),
        .tx_address   (tx_address),
        .tx_data      (tx_data),
        .tx_burst     (tx_burst),
        .master_valid (master_valid),
        .master_ready (master_ready),
        .read_en      (read_en),
        .write_en     (write_en),
        .slave_valid  (slave_valid),
        .slave_ready  (slave_ready),
        .rx_data      (rx_data),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [11:0] addr;
        logic [7:0]  wdata;
        logic [12:0] burst;
        logic [7:0]  rbyte;
        int          sr_delay;   // cycles slave_ready is held low in WAIT_SLV
        int          pause_at;   // read bit index preceded by 2 slave_valid=0 cycles (8 = none)
        int          abort_at;   // SEND cycle at which reset is asserted (13 = none)
    } vec_t;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
    } rsp_t;

    rsp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic bit_at(input logic [31:0] val, input int i);
        return val[i];
    endfunction

    // All outputs as one vector: {req_ready, master_valid, master_ready, read_en,
    // write_en, tx_address, tx_data, tx_burst, rsp_valid, rsp_err, rsp_rdata}.
    function automatic logic [17:0] all_outs();
        return {req_ready, master_valid, master_ready, read_en, write_en,
                tx_address, tx_data, tx_burst, rsp_valid, rsp_err, rsp_rdata};
    endfunction

    // Scoreboard: compare every completion against the oldest pending expectation.
    always @(negedge clk) begin
        rsp_t e;
        if (rsp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: rsp_valid=1 required 0 (no pending request) at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    // One full transaction; starts and ends at a sample point with the DUT in IDLE.
    task automatic run_txn(input vec_t v, input bit keep_valid);
        int         k;
        int         p;
        logic [7:0] exp_rd;
        logic       ea;
        logic       ed;
        logic       eb;

        chk("idle_req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = v.write;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_burst = v.burst;
        exp_rd    = v.write ? 8'h00 : v.rbyte;
        sb_q.push_back('{rdata: exp_rd, err: 1'b0});
        @(posedge clk); #1;
        if (!keep_valid) req_valid = 1'b0;
        chk("dir_enables", 32'({read_en, write_en}), 32'({~v.write, v.write}));
        chk("rdata_cleared_on_accept", 32'(rsp_rdata), 32'd0);

        slave_ready = 1'b0;
        for (int w = 0; w < v.sr_delay; w++) begin
            chk("wait_quiet", 32'({req_ready, master_valid, master_ready, rsp_valid}), 32'd0);
            @(posedge clk); #1;
        end
        slave_ready = 1'b1;
        @(posedge clk); #1;
        slave_ready = 1'b0;

        for (int i = 0; i < 13; i++) begin
            ea = (i < 12) ? bit_at(32'(v.addr), i) : 1'b0;
            ed = (v.write && i < 8) ? bit_at(32'(v.wdata), i) : 1'b0;
            eb = bit_at(32'(v.burst), i);
            chk("send_bits", 32'({req_ready, master_valid, master_ready, rsp_valid,
                                  tx_address, tx_data, tx_burst}),
                32'({4'b0100, ea, ed, eb}));
            if (i == v.abort_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                chk("reset_abort_outs", 32'(all_outs()), 32'h20000);
                void'(sb_q.pop_back());
                return;
            end
            @(posedge clk); #1;
        end

        if (!v.write) begin
            k = 0;
            p = 0;
            while (k < 8) begin
                chk("read_phase", 32'({master_ready, master_valid, rsp_valid, read_en}), 32'h9);
                if (k == v.pause_at && p < 2) begin
                    slave_valid = 1'b0;
                    p++;
                end else begin
                    slave_valid = 1'b1;
                    rx_data     = bit_at(32'(v.rbyte), k);
                    k++;
                end
                @(posedge clk); #1;
            end
            slave_valid = 1'b0;
            rx_data     = 1'b0;
        end

        // Writes reach here 15 + sr_delay cycles after accept (WAIT_SLV is cycle 1).
        chk("done_flags", 32'({req_ready, master_valid, master_ready, rsp_valid, read_en, write_en}),
            32'({4'b0001, ~v.write, v.write}));
        @(posedge clk); #1;
        chk("idle_after_done", 32'({req_ready, rsp_valid, read_en, write_en, master_valid}), 32'h10);
        chk("rdata_hold", 32'(rsp_rdata), 32'(exp_rd));
    endtask

    vec_t vecs[7];
    vec_t b2b_a;
    vec_t b2b_b;
    vec_t long_wait;

    initial begin
        vecs[0] = '{write: 1'b1, addr: 12'hADD, wdata: 8'hBD, burst: 13'h15AD, rbyte: 8'h00,
                    sr_delay: 0,  pause_at: 8, abort_at: 13};
        vecs[1] = '{write: 1'b0, addr: 12'h123, wdata: 8'hFF, burst: 13'h0F0F, rbyte: 8'h5A,
                    sr_delay: 0,  pause_at: 4, abort_at: 13};
        vecs[2] = '{write: 1'b1, addr: 12'h7FF, wdata: 8'h01, burst: 13'h1FFF, rbyte: 8'h00,
                    sr_delay: 20, pause_at: 8, abort_at: 13};
        vecs[3] = '{write: 1'b0, addr: 12'hFFF, wdata: 8'h00, burst: 13'h0001, rbyte: 8'hA5,
                    sr_delay: 3,  pause_at: 0, abort_at: 13};
        vecs[4] = '{write: 1'b1, addr: 12'h555, wdata: 8'hFF, burst: 13'h0AAA, rbyte: 8'h00,
                    sr_delay: 0,  pause_at: 8, abort_at: 6};
        vecs[5] = '{write: 1'b0, addr: 12'h000, wdata: 8'h00, burst: 13'h0000, rbyte: 8'hFF,
                    sr_delay: 1,  pause_at: 7, abort_at: 13};
        vecs[6] = '{write: 1'b1, addr: 12'h800, wdata: 8'h80, burst: 13'h1000, rbyte: 8'h00,
                    sr_delay: 0,  pause_at: 8, abort_at: 13};
        b2b_a   = '{write: 1'b1, addr: 12'h3C5, wdata: 8'h96, burst: 13'h0123, rbyte: 8'h00,
                    sr_delay: 0,  pause_at: 8, abort_at: 13};
        b2b_b   = '{write: 1'b0, addr: 12'hC3A, wdata: 8'h00, burst: 13'h1ABC, rbyte: 8'h3C,
                    sr_delay: 0,  pause_at: 2, abort_at: 13};
        long_wait = '{write: 1'b1, addr: 12'h0F0, wdata: 8'h0F, burst: 13'h0F0F, rbyte: 8'h00,
                      sr_delay: 300, pause_at: 8, abort_at: 13};

        reset       = 1'b1;
        req_valid   = 1'b1;
        req_write   = 1'b1;
        req_addr    = 12'h111;
        req_wdata   = 8'h22;
        req_burst   = 13'h0333;
        slave_valid = 1'b0;
        slave_ready = 1'b1;
        rx_data     = 1'b0;

        // Reset wins over a simultaneous request.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", 32'(all_outs()), 32'h20000);
        req_valid   = 1'b0;
        slave_ready = 1'b0;
        reset       = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_idle", 32'(all_outs()), 32'h20000);

        for (int n = 0; n < 7; n++) begin
            run_txn(vecs[n], 1'b0);
        end

        // req_valid held high: second request accepted only after DONE.
        run_txn(b2b_a, 1'b1);
        run_txn(b2b_b, 1'b0);

`ifndef MASTER_TX_TIMEOUT_EN
        // Without the timeout build the master waits indefinitely.
        run_txn(long_wait, 1'b0);
`else
        chk("to_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 12'h456;
        req_wdata = 8'h00;
        req_burst = 13'h0000;
        sb_q.push_back('{rdata: 8'h00, err: 1'b1});
        @(posedge clk); #1;
        req_valid   = 1'b0;
        slave_ready = 1'b0;
        for (int c = 1; c < 255; c++) begin
            @(posedge clk); #1;
        end
        chk("to_not_early", 32'({rsp_valid, master_valid}), 32'd0);
        @(posedge clk); #1;
        chk("to_rsp", 32'({rsp_valid, rsp_err}), 32'h3);
        @(posedge clk); #1;
        chk("to_back_idle", 32'({req_ready, rsp_valid, rsp_err}), 32'h4);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
